// File: rtl/btn_debounce_pulse.sv
// Pushbutton debouncer: 2-flop sync, 2^N_DC-cycle press/release windows, Moore outputs.
// Press-to-SCEN latency 2^N_DC+2 edges; MCEN repeats every 2^N_DC+1 while held; no backpressure.
module btn_debounce_pulse #(
    parameter int N_DC = 20
) (
    input  logic Clk,
    input  logic reset,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN
);

    typedef enum logic [2:0] {
        INI     = 3'd0,
        WQ      = 3'd1,
        SCEN_ST = 3'd2,
        HOLD    = 3'd3,
        MCEN_ST = 3'd4,
        WFCR    = 3'd5
    } state_t;

    localparam logic [N_DC-1:0] CNT_MAX = '1;
    localparam logic [N_DC-1:0] CNT_ONE = N_DC'(1);

    state_t            state_q, state_d;
    logic [N_DC-1:0]   cnt_q, cnt_d;
    logic              sync1_q;
    logic              pb_s_q;

    always_ff @(posedge Clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            pb_s_q  <= 1'b0;
            state_q <= INI;
            cnt_q   <= '0;
        end else begin
            sync1_q <= PB;
            pb_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every state change clears the counter; it never wraps because max always exits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INI: begin
                cnt_d = '0;
                if (pb_s_q) state_d = WQ;
            end
            WQ: begin
                if (!pb_s_q) begin
                    state_d = INI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = SCEN_ST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SCEN_ST: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                if (!pb_s_q) begin
                    state_d = WFCR;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = MCEN_ST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            MCEN_ST: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            WFCR: begin
                if (pb_s_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = INI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = INI;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        DPB  = 1'b0;
        SCEN = 1'b0;
        MCEN = 1'b0;
        unique case (state_q)
            SCEN_ST: begin
                DPB  = 1'b1;
                SCEN = 1'b1;
                MCEN = 1'b1;
            end
            MCEN_ST: begin
                DPB  = 1'b1;
                MCEN = 1'b1;
            end
            HOLD, WFCR: DPB = 1'b1;
            default: begin
                DPB  = 1'b0;
                SCEN = 1'b0;
                MCEN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
module tb_btn_debounce_pulse;

    logic Clk;
    logic reset;
    logic PB;
    logic DPB;
    logic SCEN;
    logic MCEN;

    int checks;
    int errors;

    btn_debounce_pulse #(.N_DC(3)) dut (
        .Clk   (Clk),
        .reset (reset),
        .PB    (PB),
        .DPB   (DPB),
        .SCEN  (SCEN),
        .MCEN  (MCEN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic pb, input logic rst);
        PB    = pb;
        reset = rst;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1);
        checks++;
        if (DPB !== 1'b0) begin
            errors++;
            $display("FAIL reset_dpb: got %b want 0", DPB);
        end
        checks++;
        if (SCEN !== 1'b0) begin
            errors++;
            $display("FAIL reset_scen: got %b want 0", SCEN);
        end
        checks++;
        if (MCEN !== 1'b0) begin
            errors++;
            $display("FAIL reset_mcen: got %b want 0", MCEN);
        end
        reset = 1'b0;
    endtask

    task automatic test_press();
        do_reset();
        for (int e = 0; e < 12; e++) begin
            step(1'b1, 1'b0);
            checks++;
            if (SCEN !== (e == 10)) begin
                errors++;
                $display("FAIL press_scen e=%0d: got %b want %b", e, SCEN, (e == 10));
            end
            checks++;
            if (MCEN !== (e == 10)) begin
                errors++;
                $display("FAIL press_mcen e=%0d: got %b want %b", e, MCEN, (e == 10));
            end
            checks++;
            if (DPB !== (e >= 10)) begin
                errors++;
                $display("FAIL press_dpb e=%0d: got %b want %b", e, DPB, (e >= 10));
            end
        end
    endtask

    task automatic test_bounce();
        logic pb;
        do_reset();
        for (int e = 0; e < 26; e++) begin
            pb = (e <= 4) || (e >= 6 && e <= 12);
            step(pb, 1'b0);
            checks++;
            if ({DPB, SCEN, MCEN} !== 3'b000) begin
                errors++;
                $display("FAIL bounce e=%0d: got dpb/scen/mcen=%b want 000", e, {DPB, SCEN, MCEN});
            end
        end
    endtask

    task automatic test_repeat();
        logic exp_m;
        do_reset();
        for (int e = 0; e < 40; e++) begin
            step(1'b1, 1'b0);
            exp_m = (e == 10) || (e == 19) || (e == 28) || (e == 37);
            checks++;
            if (SCEN !== (e == 10)) begin
                errors++;
                $display("FAIL repeat_scen e=%0d: got %b want %b", e, SCEN, (e == 10));
            end
            checks++;
            if (MCEN !== exp_m) begin
                errors++;
                $display("FAIL repeat_mcen e=%0d: got %b want %b", e, MCEN, exp_m);
            end
            checks++;
            if (DPB !== (e >= 10)) begin
                errors++;
                $display("FAIL repeat_dpb e=%0d: got %b want %b", e, DPB, (e >= 10));
            end
        end
    endtask

    task automatic test_release_glitch();
        logic pb;
        logic exp_m;
        do_reset();
        for (int e = 0; e < 33; e++) begin
            pb = !(e >= 14 && e <= 17);
            step(pb, 1'b0);
            exp_m = (e == 10) || (e == 28);
            checks++;
            if (SCEN !== (e == 10)) begin
                errors++;
                $display("FAIL glitch_scen e=%0d: got %b want %b", e, SCEN, (e == 10));
            end
            checks++;
            if (MCEN !== exp_m) begin
                errors++;
                $display("FAIL glitch_mcen e=%0d: got %b want %b", e, MCEN, exp_m);
            end
            checks++;
            if (DPB !== (e >= 10)) begin
                errors++;
                $display("FAIL glitch_dpb e=%0d: got %b want %b", e, DPB, (e >= 10));
            end
        end
    endtask

    task automatic test_clean_release();
        logic exp_d;
        do_reset();
        for (int e = 0; e < 28; e++) begin
            step((e <= 14), 1'b0);
            exp_d = (e >= 10) && (e <= 24);
            checks++;
            if (DPB !== exp_d) begin
                errors++;
                $display("FAIL release_dpb e=%0d: got %b want %b", e, DPB, exp_d);
            end
            checks++;
            if (MCEN !== (e == 10)) begin
                errors++;
                $display("FAIL release_mcen e=%0d: got %b want %b", e, MCEN, (e == 10));
            end
        end
        for (int e = 0; e < 12; e++) begin
            step(1'b1, 1'b0);
            checks++;
            if (SCEN !== (e == 10)) begin
                errors++;
                $display("FAIL repress_scen e=%0d: got %b want %b", e, SCEN, (e == 10));
            end
            checks++;
            if (DPB !== (e >= 10)) begin
                errors++;
                $display("FAIL repress_dpb e=%0d: got %b want %b", e, DPB, (e >= 10));
            end
        end
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        for (int e = 0; e < 14; e++) begin
            step(1'b1, 1'b0);
        end
        checks++;
        if (DPB !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_dpb: got %b want 1", DPB);
        end
        step(1'b1, 1'b1);
        checks++;
        if ({DPB, SCEN, MCEN} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b want 000", {DPB, SCEN, MCEN});
        end
        for (int e = 0; e < 12; e++) begin
            step(1'b1, 1'b0);
            checks++;
            if (SCEN !== (e == 10)) begin
                errors++;
                $display("FAIL midreset_scen e=%0d: got %b want %b", e, SCEN, (e == 10));
            end
            checks++;
            if (DPB !== (e >= 10)) begin
                errors++;
                $display("FAIL midreset_dpb e=%0d: got %b want %b", e, DPB, (e >= 10));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        PB     = 1'b0;
        reset  = 1'b1;
        test_reset();
        test_press();
        test_bounce();
        test_repeat();
        test_release_glitch();
        test_clean_release();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
